vector_issue_queue: RTL and testbench
=====================================

# vector_issue_queue

Buffers vector instructions leaving the Fetch/Decode register and sequences each one over the vector lanes as a fixed number of element beats. It sits directly downstream of the Fetch stage on the vector path. It consumes the decode-stage vector instruction word and drives a valid/ready issue port toward the vector execute lanes. It raises a stall toward the hazard unit when it cannot accept more work.

## Interface
- WIDTH, 26: vector instruction word width.
- DEPTH, 4: queue entries; must be a power of two, at least 2.
- BEATS, 4: element beats per vector instruction (vector length / lane count); must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- InstrDV  in  WIDTH  vector instruction held in the Fetch/Decode register; all-zero word is a bubble.
- StallOther  in  1  decode stage held by a non-vector hazard this cycle; the present InstrDV must not be accepted.
- FlushQ  in  1  discard all queued and in-flight vector work.
- IssueReady  in  1  lanes accept the current beat.
- VecStall  out  1  queue full; hazard unit ORs this into StallF/StallD.
- IssueValid  out  1  a beat is presented.
- IssueInstr  out  WIDTH  instruction at queue head.
- IssueBeat  out  log2(BEATS)  element-beat index of the presented beat.
- IssueLast  out  1  presented beat is the final beat of IssueInstr.
- QCount  out  log2(DEPTH)+1  number of occupied entries, including the head being issued.

## Operation
- Storage is a circular buffer of DEPTH × WIDTH entries with read pointer rp, write pointer wp and count cnt.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Enqueue condition: enq = (InstrDV != 0) && !StallOther && !full && !FlushQ.
  - On enq, write mem[wp] and increment wp.
- full = (cnt == DEPTH) and is decided from registered cnt only. A pop in the same cycle does not free space for a same-cycle enqueue.
- VecStall = full. It is registered-derived, so there is no combinational path from IssueReady.
- Sequencer FSM, two states:
  - IDLE: cnt == 0. IssueValid = 0, beat = 0. Go to ISSUE when cnt becomes nonzero.
  - ISSUE: IssueValid = 1, IssueInstr = mem[rp], IssueBeat = beat, IssueLast = (beat == BEATS-1).
    - On IssueValid && IssueReady, beat increments.
    - On the last beat, beat wraps to 0, rp increments and cnt decrements (pop).
    - After the pop, stay in ISSUE if entries remain, otherwise go to IDLE.
- cnt update: cnt + enq − pop. Simultaneous enq and pop leave cnt unchanged.
- IssueReady low holds all issue outputs stable; beat does not advance.
- FlushQ, taking priority over enq and pop, resets rp, wp, cnt and beat to 0 and the FSM to IDLE at the next edge. Queue contents are don't-care.
- reset == 0 has the same effect as FlushQ. It is valid mid-issue: the partial instruction is dropped, with no further beats.

## Timing
- Reset values: VecStall 0, IssueValid 0, IssueInstr don't-care (0 preferred), IssueBeat 0, IssueLast 0, QCount 0.
- Latency: an instruction enqueued at edge N shows IssueValid = 1 with beat 0 in the cycle after edge N, provided the queue was empty.
- Throughput: one instruction per BEATS cycles with IssueReady held high. Back-to-back instructions have no bubble between the last beat of one and beat 0 of the next.
- VecStall rises in the cycle after the enqueue that fills the queue. It falls in the cycle after the first pop from full.
- The hazard unit holds InstrDV stable while VecStall || StallOther. The same word is therefore accepted exactly once, on the first cycle both are low.
- Issue outputs are combinational from registered state only.

## Test plan
- Reset and basic issue: hold reset low 2 cycles, then apply InstrDV = 0x0ABCDEF for one cycle with IssueReady = 1.
  - Required: QCount 0→1; IssueValid for 4 cycles with IssueBeat 0,1,2,3; IssueLast only on beat 3; QCount back to 0.
- Bubble rejection: InstrDV = 0 for 10 cycles → QCount stays 0, IssueValid stays 0.
- Fill and stall: IssueReady = 0, then apply 4 distinct instructions.
  - Required: VecStall = 1 after the 4th; a held 5th word is not enqueued.
  - Release IssueReady: after 4 beats VecStall drops, the 5th is accepted once, and issue order matches enqueue order with pointer wrap.
- Backpressure: toggle IssueReady 1,0,0,1,1,0,1 during one instruction → beats advance only on ready cycles; IssueInstr and IssueBeat stay stable while ready is low.
- StallOther: a nonzero InstrDV held 3 cycles with StallOther = 1, then 1 cycle with StallOther = 0 → exactly one enqueue.
- Flush/reset mid-issue: 3 queued, head at beat 2, then pulse FlushQ (and separately reset = 0) → next cycle IssueValid 0, QCount 0, and a new enqueue issues from beat 0.

Source files
------------

// File: rtl/vector_issue_queue.sv
// Vector issue queue: buffers decoded vector instructions in a circular buffer
// and sequences the head instruction over BEATS element beats on a valid/ready port.
module vector_issue_queue #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4,
  parameter int BEATS = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int BW = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] InstrDV,
  input  logic             StallOther,
  input  logic             FlushQ,
  input  logic             IssueReady,
  output logic             VecStall,
  output logic             IssueValid,
  output logic [WIDTH-1:0] IssueInstr,
  output logic [BW-1:0]    IssueBeat,
  output logic             IssueLast,
  output logic [PW:0]      QCount,
  output logic             dbg_state
);

  // Issue handshake: a beat transfers on any cycle where IssueValid && IssueReady
  // are both high at the rising edge; while IssueReady is low every issue output holds.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rp;
  logic [PW-1:0]    wp;
  logic [PW:0]      cnt;
  logic [PW:0]      cnt_next;
  logic [BW-1:0]    beat;
  state_t           state;
  state_t           state_next;

  logic clear;
  logic full;
  logic enq;
  logic fire;
  logic last_beat;
  logic pop;

  // Reset and flush share one clearing path; both win over enqueue and pop.
  assign clear     = FlushQ || !reset;
  assign full      = (cnt == (PW+1)'(DEPTH));
  assign enq       = (InstrDV != '0) && !StallOther && !full && !clear;
  assign fire      = (state == S_ISSUE) && IssueReady;
  assign last_beat = (beat == BW'(BEATS - 1));
  assign pop       = fire && last_beat && !clear;

  always_comb begin
    cnt_next = cnt;
    case ({enq, pop})
      2'b10:   cnt_next = cnt + (PW+1)'(1);
      2'b01:   cnt_next = cnt - (PW+1)'(1);
      default: cnt_next = cnt;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cnt_next != '0) state_next = S_ISSUE;
        S_ISSUE: if (cnt_next == '0) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs, from registered state only
  always_comb begin
    IssueValid = 1'b0;
    IssueInstr = '0;
    IssueBeat  = '0;
    IssueLast  = 1'b0;
    if (state == S_ISSUE) begin
      IssueValid = 1'b1;
      IssueInstr = mem[rp];
      IssueBeat  = beat;
      IssueLast  = last_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || FlushQ) begin
      rp   <= '0;
      wp   <= '0;
      cnt  <= '0;
      beat <= '0;
    end else begin
      if (enq) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      // BEATS is a power of two, so the beat counter wraps to 0 after the last beat.
      if (fire) beat <= beat + BW'(1);
      cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wp] <= InstrDV;
  end

  assign VecStall  = full;
  assign QCount    = cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_vector_issue_queue.sv
// Directed bench for vector_issue_queue: a driver pushes expected beats into a
// queue, and a negedge monitor pops and compares each transferred beat.
module tb_vector_issue_queue;

  localparam int WIDTH = 26;
  localparam int DEPTH = 4;
  localparam int BEATS = 4;
  localparam int EW    = WIDTH + 2 + 1;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] InstrDV;
  logic             StallOther;
  logic             FlushQ;
  logic             IssueReady;
  logic             VecStall;
  logic             IssueValid;
  logic [WIDTH-1:0] IssueInstr;
  logic [1:0]       IssueBeat;
  logic             IssueLast;
  logic [2:0]       QCount;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  vector_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BEATS(BEATS)) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrDV    (InstrDV),
    .StallOther (StallOther),
    .FlushQ     (FlushQ),
    .IssueReady (IssueReady),
    .VecStall   (VecStall),
    .IssueValid (IssueValid),
    .IssueInstr (IssueInstr),
    .IssueBeat  (IssueBeat),
    .IssueLast  (IssueLast),
    .QCount     (QCount),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_instr(input logic [WIDTH-1:0] w);
    for (int b = 0; b < BEATS; b++) begin
      exp_q.push_back({w, 2'(b), (b == BEATS - 1)});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (QCount != 0 || IssueValid); i++) tick();
    check("drain_empty", {QCount, IssueValid}, 64'h0);
  endtask

  // Scoreboard monitor: compares transferred beats and holds during backpressure
  logic             hold_pending = 1'b0;
  logic [WIDTH+1:0] hold_val;

  always @(negedge clk) begin
    if (IssueValid) begin
      if (hold_pending) begin
        checks++;
        if ({IssueInstr, IssueBeat} !== hold_val) begin
          errors++;
          $display("FAIL hold_stable: got %0h expected %0h", {IssueInstr, IssueBeat}, hold_val);
        end
      end
      if (IssueReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {IssueInstr, IssueBeat, IssueLast});
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({IssueInstr, IssueBeat, IssueLast} !== e) begin
            errors++;
            $display("FAIL beat: got %0h expected %0h", {IssueInstr, IssueBeat, IssueLast}, e);
          end
        end
        hold_pending <= 1'b0;
      end else begin
        hold_pending <= 1'b1;
        hold_val     <= {IssueInstr, IssueBeat};
      end
    end else begin
      hold_pending <= 1'b0;
    end
  end

  // Directed stimulus
  logic [WIDTH-1:0] fill_words [5];
  logic [6:0]       bp_pattern;
  int               n;
  int               exp_beat;

  initial begin
    fill_words[0] = 26'h0111111;
    fill_words[1] = 26'h0222222;
    fill_words[2] = 26'h0333333;
    fill_words[3] = 26'h0044444;
    fill_words[4] = 26'h0055555;
    bp_pattern    = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1

    reset = 1'b0; InstrDV = '0; StallOther = 1'b0; FlushQ = 1'b0; IssueReady = 1'b1;
    tick(); tick();
    check("rst_valid", IssueValid, 0);
    check("rst_qcount", QCount, 0);
    check("rst_vecstall", VecStall, 0);
    check("rst_beat", IssueBeat, 0);
    check("rst_last", IssueLast, 0);
    reset = 1'b1;
    tick();

    // Basic issue
    InstrDV = 26'h0ABCDEF;
    push_instr(26'h0ABCDEF);
    tick();
    InstrDV = '0;
    check("basic_qcount", QCount, 1);
    check("basic_valid", IssueValid, 1);
    check("basic_beat0", IssueBeat, 0);
    for (int i = 0; i < BEATS; i++) tick();
    check("basic_done", {QCount, IssueValid}, 0);

    // Bubble rejection
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bubble_state", {QCount, IssueValid}, 0);
    end

    // Fill and stall, with pointer wrap
    IssueReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      InstrDV = fill_words[i];
      push_instr(fill_words[i]);
      tick();
    end
    check("fill_vecstall", VecStall, 1);
    check("fill_qcount", QCount, 4);
    InstrDV = fill_words[4];
    tick(); tick();
    check("held_not_enq", QCount, 4);
    IssueReady = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && VecStall; i++) begin
      tick();
      n++;
    end
    check("stall_release_cycles", n, 4);
    check("after_pop_qcount", QCount, 3);
    push_instr(fill_words[4]);
    tick();
    InstrDV = '0;
    check("fifth_accepted", QCount, 4);
    drain();

    // Backpressure during one instruction
    InstrDV = 26'h0FEDCBA;
    push_instr(26'h0FEDCBA);
    tick();
    InstrDV = '0;
    exp_beat = 0;
    for (int i = 0; i < 7; i++) begin
      IssueReady = bp_pattern[i];
      check("bp_valid", IssueValid, 1);
      check("bp_beat", IssueBeat, exp_beat);
      tick();
      if (bp_pattern[i]) exp_beat++;
    end
    IssueReady = 1'b1;
    check("bp_done", {QCount, IssueValid}, 0);

    // StallOther holds off enqueue
    InstrDV = 26'h0135790; StallOther = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stallother_qcount", QCount, 0);
    end
    StallOther = 1'b0;
    push_instr(26'h0135790);
    tick();
    InstrDV = '0;
    check("stallother_enq", QCount, 1);
    drain();

    // Flush mid-issue (k == 0), then reset mid-issue (k == 1)
    for (int k = 0; k < 2; k++) begin
      IssueReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
        InstrDV = fill_words[i] ^ 26'h1000000;
        push_instr(fill_words[i] ^ 26'h1000000);
        tick();
      end
      InstrDV = '0;
      IssueReady = 1'b1;
      tick(); tick();
      IssueReady = 1'b0;
      check("pre_clear_beat", IssueBeat, 2);
      check("pre_clear_qcount", QCount, 3);
      if (k == 0) FlushQ = 1'b1;
      else        reset  = 1'b0;
      exp_q.delete();
      tick();
      FlushQ = 1'b0; reset = 1'b1;
      check("clear_valid", IssueValid, 0);
      check("clear_qcount", QCount, 0);
      check("clear_vecstall", VecStall, 0);
      IssueReady = 1'b1;
      InstrDV = 26'h0C0FFEE;
      push_instr(26'h0C0FFEE);
      tick();
      InstrDV = '0;
      check("clear_new_valid", IssueValid, 1);
      check("clear_new_beat", IssueBeat, 0);
      drain();
    end

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
